// File: rtl/atoi2.sv
// Parses ASCII lines "num0<sep>num1\n" into pairs of SIZE-bit unsigned integers; doValid rises on the LF-accept edge.
// Backpressure: diReady drops while a finished pair waits in Done for doReady, so no character is lost.
module atoi2 #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      di,
  input  logic            diValid,
  output logic            diReady,
  output logic [SIZE-1:0] num0,
  output logic [SIZE-1:0] num1,
  output logic            ovf,
  output logic            doValid,
  input  logic            doReady,
  output logic            err
);
  localparam int W = SIZE + 4;

  typedef enum logic [1:0] {FIELD0, FIELD1, SKIP, DONE} state_t;

  state_t          state;
  logic            seen0, seen1, trail;
  logic            accept, is_digit, is_sep, is_cr, is_lf, bad_line;
  logic [SIZE-1:0] acc;
  logic [W-1:0]    mac;
  logic            mac_ovf;

  assign diReady  = !rst && (state != DONE);
  assign accept   = diValid && diReady;
  assign is_digit = (di >= 8'h30) && (di <= 8'h39);
  assign is_sep   = (di == 8'h20) || (di == 8'h09) || (di == 8'h2C);
  assign is_cr    = (di == 8'h0D);
  assign is_lf    = (di == 8'h0A);

  // Four guard bits hold acc*10+d exactly, so any carry above SIZE means overflow.
  assign acc     = (state == FIELD1) ? num1 : num0;
  assign mac     = W'(acc) * W'(10) + W'(di[3:0]);
  assign mac_ovf = |mac[W-1:SIZE];

  assign bad_line = accept && is_lf &&
                    ((state == FIELD0 && seen0) || (state == FIELD1 && !seen1) || (state == SKIP));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FIELD0;
      num0    <= '0;
      num1    <= '0;
      ovf     <= 1'b0;
      doValid <= 1'b0;
      err     <= 1'b0;
      seen0   <= 1'b0;
      seen1   <= 1'b0;
      trail   <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state == DONE) begin
        if (doValid && doReady) begin
          doValid <= 1'b0;
          num0    <= '0;
          num1    <= '0;
          ovf     <= 1'b0;
          seen0   <= 1'b0;
          seen1   <= 1'b0;
          trail   <= 1'b0;
          state   <= FIELD0;
        end
      end else if (bad_line) begin
        err   <= 1'b1;
        num0  <= '0;
        num1  <= '0;
        ovf   <= 1'b0;
        seen0 <= 1'b0;
        seen1 <= 1'b0;
        trail <= 1'b0;
        state <= FIELD0;
      end else if (accept && !is_cr) begin
        case (state)
          FIELD0: begin
            if (is_digit) begin
              num0  <= mac[SIZE-1:0];
              ovf   <= ovf | mac_ovf;
              seen0 <= 1'b1;
            end else if (is_sep) begin
              if (seen0) state <= FIELD1;
            end else if (!is_lf) begin
              state <= SKIP;
            end
          end
          FIELD1: begin
            if (is_digit) begin
              if (trail) begin
                state <= SKIP;
              end else begin
                num1  <= mac[SIZE-1:0];
                ovf   <= ovf | mac_ovf;
                seen1 <= 1'b1;
              end
            end else if (is_sep) begin
              if (seen1) trail <= 1'b1;
            end else if (is_lf) begin
              state   <= DONE;
              doValid <= 1'b1;
            end else begin
              state <= SKIP;
            end
          end
          default: ;  // Skip swallows everything; its terminating LF is a bad_line
        endcase
      end
    end
  end
endmodule

// File: tb/tb_atoi2.sv
// Bench for atoi2: directed scenarios plus randomized lines against a grammar-level reference model.
module tb_atoi2;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  di = 8'h00;
  logic        diValid = 1'b0;
  logic        doReady = 1'b0;

  logic        rdy64, ovf64, vld64, err64;
  logic [63:0] n0_64, n1_64;
  logic        rdy8, ovf8, vld8, err8;
  logic [7:0]  n0_8, n1_8;

  atoi2 #(.SIZE(64)) dut64 (
    .clk(clk), .rst(rst), .di(di), .diValid(diValid), .diReady(rdy64),
    .num0(n0_64), .num1(n1_64), .ovf(ovf64), .doValid(vld64), .doReady(doReady), .err(err64)
  );

  atoi2 #(.SIZE(8)) dut8 (
    .clk(clk), .rst(rst), .di(di), .diValid(diValid), .diReady(rdy8),
    .num0(n0_8), .num1(n1_8), .ovf(ovf8), .doValid(vld8), .doReady(doReady), .err(err8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        o;
  } pair_t;

  pair_t got64[$];
  pair_t got8[$];
  int    errs64 = 0;
  int    errs8 = 0;
  int    chk_cnt = 0;
  int    pass_cnt = 0;
  int    stalls = 0;
  logic  rnd_run = 1'b0;

  // Record every completed handshake and every error pulse seen on the outputs.
  always @(negedge clk) begin
    if (!rst) begin
      if (vld64 && doReady) got64.push_back('{n0_64, n1_64, ovf64});
      if (vld8 && doReady) got8.push_back('{{56'b0, n0_8}, {56'b0, n1_8}, ovf8});
      if (err64) errs64++;
      if (err8) errs8++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_q(input logic [7:0] q[$], input int gap_pct);
    for (int i = 0; i < q.size(); i++) begin
      int waitc;
      if ($urandom_range(0, 99) < gap_pct) begin
        diValid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      di = q[i];
      diValid = 1'b1;
      waitc = 0;
      @(negedge clk);
      while (!rdy64 && waitc < 200) begin
        waitc++;
        stalls++;
        @(negedge clk);
      end
      if (!rdy64) begin
        chk_cnt++;
        $display("FAIL accept_timeout: diReady=%0b required 1", rdy64);
      end
      @(posedge clk);
      #1;
    end
    diValid = 1'b0;
  endtask

  task automatic send_str(input string s);
    logic [7:0] q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    send_q(q, 0);
  endtask

  function automatic logic f_sep(input logic [7:0] c);
    return c == 8'h20 || c == 8'h09 || c == 8'h2C;
  endfunction

  function automatic logic f_dig(input logic [7:0] c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction

  // Decimal value of t[lo..hi) reduced mod 2^size; big says the true value reached 2^size.
  task automatic dec(input logic [7:0] t[$], input int lo, input int hi, input int size,
                     output logic [63:0] v, output logic big);
    logic [127:0] lim, m, exact;
    lim = 128'd1 << size;
    m = 0;
    exact = 0;
    big = 1'b0;
    for (int k = lo; k < hi; k++) begin
      m = (m * 10 + 128'(t[k] - 8'h30)) % lim;
      if (!big) begin
        exact = exact * 10 + 128'(t[k] - 8'h30);
        if (exact >= lim) big = 1'b1;
      end
    end
    v = m[63:0];
  endtask

  // Line grammar after dropping CRs: sep* (empty) | sep* digit+ sep+ digit+ sep*; anything else is an error.
  task automatic model(input logic [7:0] q[$], input int size, output int kind,
                       output logic [63:0] a, output logic [63:0] b, output logic o);
    logic [7:0] t[$];
    int i, s0, e0, s1, e1;
    logic o0, o1;
    kind = 2; a = 0; b = 0; o = 0;
    foreach (q[k]) if (q[k] != 8'h0D && q[k] != 8'h0A) t.push_back(q[k]);
    i = 0;
    while (i < t.size() && f_sep(t[i])) i++;
    if (i == t.size()) begin kind = 0; return; end
    s0 = i;
    while (i < t.size() && f_dig(t[i])) i++;
    e0 = i;
    if (e0 == s0 || i == t.size() || !f_sep(t[i])) return;
    while (i < t.size() && f_sep(t[i])) i++;
    s1 = i;
    while (i < t.size() && f_dig(t[i])) i++;
    e1 = i;
    if (e1 == s1) return;
    while (i < t.size() && f_sep(t[i])) i++;
    if (i != t.size()) return;
    kind = 1;
    dec(t, s0, e0, size, a, o0);
    dec(t, s1, e1, size, b, o1);
    o = o0 | o1;
  endtask

  task automatic gen_line(output logic [7:0] q[$]);
    string seps, alpha;
    int kind, n;
    seps = " \t,";
    alpha = "0123456789 ,\t\r-x";
    q.delete();
    kind = $urandom_range(0, 9);
    if (kind == 0) begin
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) q.push_back(($urandom_range(0, 3) == 0) ? 8'h0D : seps[$urandom_range(0, 2)]);
    end else if (kind <= 6) begin
      for (int f = 0; f < 2; f++) begin
        n = $urandom_range(0, 2);
        if (f == 1 && n == 0) n = 1;
        for (int i = 0; i < n; i++) q.push_back(seps[$urandom_range(0, 2)]);
        n = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 22) : $urandom_range(1, 4);
        for (int i = 0; i < n; i++) q.push_back(8'h30 + 8'($urandom_range(0, 9)));
        if ($urandom_range(0, 4) == 0) q.push_back(8'h0D);
      end
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) q.push_back(seps[$urandom_range(0, 2)]);
    end else begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) q.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
    end
    if ($urandom_range(0, 3) == 0) q.push_back(8'h0D);
    q.push_back(8'h0A);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (rdy64 !== 1'b0 || rdy8 !== 1'b0) $display("FAIL reset_diready: got %0b/%0b want 0", rdy64, rdy8);
    else pass_cnt++;
    chk_cnt++;
    if (n0_64 !== 64'd0 || n1_64 !== 64'd0 || ovf64 !== 1'b0 || vld64 !== 1'b0 || err64 !== 1'b0)
      $display("FAIL reset_outputs: got num0=%0d num1=%0d ovf=%0b vld=%0b err=%0b want all 0",
               n0_64, n1_64, ovf64, vld64, err64);
    else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (rdy64 !== 1'b1) $display("FAIL reset_release_diready: got %0b want 1", rdy64);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int e;
    doReady = 1'b1;
    got64.delete();
    e = errs64;
    send_str("12 34\n");
    chk_cnt++;
    if (vld64 !== 1'b1 || n0_64 !== 64'd12 || n1_64 !== 64'd34 || ovf64 !== 1'b0)
      $display("FAIL basic_pair: got vld=%0b %0d,%0d ovf=%0b want 1 12,34 0", vld64, n0_64, n1_64, ovf64);
    else pass_cnt++;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (vld64 !== 1'b0 || got64.size() != 1) $display("FAIL basic_handshake: got vld=%0b pairs=%0d want 0 1", vld64, got64.size());
    else pass_cnt++;
    chk_cnt++;
    if (errs64 != e) $display("FAIL basic_no_err: got %0d err pulses want 0", errs64 - e);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    doReady = 1'b1;
    got64.delete();
    stalls = 0;
    send_str("  7\t\t8  \r\n0,0\n");
    @(posedge clk);
    #1;
    chk_cnt++;
    if (got64.size() != 2) $display("FAIL b2b_count: got %0d pairs want 2", got64.size());
    else if (got64[0].a !== 64'd7 || got64[0].b !== 64'd8 || got64[1].a !== 64'd0 || got64[1].b !== 64'd0)
      $display("FAIL b2b_values: got (%0d,%0d)(%0d,%0d) want (7,8)(0,0)", got64[0].a, got64[0].b, got64[1].a, got64[1].b);
    else pass_cnt++;
    chk_cnt++;
    if (stalls != 1) $display("FAIL b2b_done_stall: got %0d diReady-low cycles want 1", stalls);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    doReady = 1'b0;
    got64.delete();
    send_str("5 6\n");
    di = 8'h39;
    diValid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (rdy64 !== 1'b0 || vld64 !== 1'b1 || n0_64 !== 64'd5 || n1_64 !== 64'd6)
        $display("FAIL bp_hold[%0d]: got rdy=%0b vld=%0b %0d,%0d want 0 1 5,6", c, rdy64, vld64, n0_64, n1_64);
      else pass_cnt++;
    end
    @(posedge clk);
    #1 doReady = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_cnt++;
    if (rdy64 !== 1'b1 || vld64 !== 1'b0) $display("FAIL bp_release: got rdy=%0b vld=%0b want 1 0", rdy64, vld64);
    else pass_cnt++;
    @(posedge clk);
    #1 diValid = 1'b0;
    send_str(" 1\n");
    @(posedge clk);
    #1;
    chk_cnt++;
    if (got64.size() != 2) $display("FAIL bp_pairs: got %0d pairs want 2", got64.size());
    else if (got64[0].a !== 64'd5 || got64[0].b !== 64'd6 || got64[1].a !== 64'd9 || got64[1].b !== 64'd1)
      $display("FAIL bp_values: got (%0d,%0d)(%0d,%0d) want (5,6)(9,1)", got64[0].a, got64[0].b, got64[1].a, got64[1].b);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    doReady = 1'b1;
    got64.delete();
    got8.delete();
    send_str("255 256\n");
    send_str("3 4\n");
    send_str("18446744073709551615 18446744073709551616\n");
    send_str("007 18446744073709551615\n");
    @(posedge clk);
    #1;
    chk_cnt++;
    if (got8.size() != 4 || got64.size() != 4) $display("FAIL ovf_count: got %0d/%0d pairs want 4", got8.size(), got64.size());
    else pass_cnt++;
    if (got8.size() == 4 && got64.size() == 4) begin
      chk_cnt++;
      if (got8[0].a !== 64'd255 || got8[0].b !== 64'd0 || got8[0].o !== 1'b1)
        $display("FAIL ovf8_wrap: got %0d,%0d ovf=%0b want 255,0 1", got8[0].a, got8[0].b, got8[0].o);
      else pass_cnt++;
      chk_cnt++;
      if (got8[1].a !== 64'd3 || got8[1].b !== 64'd4 || got8[1].o !== 1'b0)
        $display("FAIL ovf8_cleared: got %0d,%0d ovf=%0b want 3,4 0", got8[1].a, got8[1].b, got8[1].o);
      else pass_cnt++;
      chk_cnt++;
      if (got64[0].a !== 64'd255 || got64[0].b !== 64'd256 || got64[0].o !== 1'b0)
        $display("FAIL ovf64_small: got %0d,%0d ovf=%0b want 255,256 0", got64[0].a, got64[0].b, got64[0].o);
      else pass_cnt++;
      chk_cnt++;
      if (got64[2].a !== 64'hFFFF_FFFF_FFFF_FFFF || got64[2].b !== 64'd0 || got64[2].o !== 1'b1)
        $display("FAIL ovf64_wrap: got %0h,%0h ovf=%0b want ffffffffffffffff,0 1", got64[2].a, got64[2].b, got64[2].o);
      else pass_cnt++;
      chk_cnt++;
      if (got64[3].a !== 64'd7 || got64[3].b !== 64'hFFFF_FFFF_FFFF_FFFF || got64[3].o !== 1'b0)
        $display("FAIL ovf64_max: got %0d,%0h ovf=%0b want 7,ffffffffffffffff 0", got64[3].a, got64[3].b, got64[3].o);
      else pass_cnt++;
    end
  endtask

  task automatic test_malformed();
    string bad[4];
    int e;
    bad[0] = "1x 2\n";
    bad[1] = "5\n";
    bad[2] = "1 2 3\n";
    bad[3] = "-5 3\n";
    doReady = 1'b1;
    got64.delete();
    e = errs64;
    for (int k = 0; k < 4; k++) begin
      send_str(bad[k]);
      chk_cnt++;
      if (err64 !== 1'b1 || vld64 !== 1'b0) $display("FAIL malformed_pulse[%0d]: got err=%0b vld=%0b want 1 0", k, err64, vld64);
      else pass_cnt++;
      @(posedge clk);
      #1;
      chk_cnt++;
      if (err64 !== 1'b0) $display("FAIL malformed_pulse_end[%0d]: got err=%0b want 0", k, err64);
      else pass_cnt++;
    end
    chk_cnt++;
    if (errs64 - e != 4 || got64.size() != 0) $display("FAIL malformed_totals: got %0d errs %0d pairs want 4 0", errs64 - e, got64.size());
    else pass_cnt++;
    send_str("4 5\n");
    @(posedge clk);
    #1;
    chk_cnt++;
    if (got64.size() != 1 || got64[0].a !== 64'd4 || got64[0].b !== 64'd5)
      $display("FAIL malformed_recover: got %0d pairs first (%0d,%0d) want 1 (4,5)", got64.size(),
               (got64.size() > 0) ? got64[0].a : 64'd0, (got64.size() > 0) ? got64[0].b : 64'd0);
    else pass_cnt++;
  endtask

  task automatic test_reset_midline();
    int e;
    doReady = 1'b1;
    got64.delete();
    e = errs64;
    send_str("12 3");
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (rdy64 !== 1'b0) $display("FAIL rst_mid_diready: got %0b want 0", rdy64);
    else pass_cnt++;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (n0_64 !== 64'd0 || n1_64 !== 64'd0 || ovf64 !== 1'b0 || vld64 !== 1'b0 || err64 !== 1'b0)
      $display("FAIL rst_mid_outputs: got %0d,%0d ovf=%0b vld=%0b err=%0b want all 0", n0_64, n1_64, ovf64, vld64, err64);
    else pass_cnt++;
    rst = 1'b0;
    send_str("9 9\n");
    @(posedge clk);
    #1;
    chk_cnt++;
    if (got64.size() != 1 || got64[0].a !== 64'd9 || got64[0].b !== 64'd9 || errs64 != e)
      $display("FAIL rst_mid_recover: got %0d pairs %0d errs want 1 pair (9,9) 0 errs", got64.size(), errs64 - e);
    else pass_cnt++;
  endtask

  task automatic test_random();
    pair_t exp64[$];
    pair_t exp8[$];
    int e64, e8, exp_err;
    got64.delete();
    got8.delete();
    e64 = errs64;
    e8 = errs8;
    exp_err = 0;
    rnd_run = 1'b1;
    fork
      begin
        for (int l = 0; l < 60; l++) begin
          logic [7:0] q[$];
          int k64, k8;
          logic [63:0] a, b;
          logic o;
          gen_line(q);
          model(q, 64, k64, a, b, o);
          if (k64 == 1) exp64.push_back('{a, b, o});
          if (k64 == 2) exp_err++;
          model(q, 8, k8, a, b, o);
          if (k8 == 1) exp8.push_back('{a, b, o});
          send_q(q, 25);
        end
        rnd_run = 1'b0;
      end
      begin
        while (rnd_run) begin
          @(posedge clk);
          #1 doReady = ($urandom_range(0, 3) != 0);
        end
      end
    join
    doReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_cnt++;
    if (got64.size() != exp64.size() || got8.size() != exp8.size())
      $display("FAIL rnd_count: got %0d/%0d pairs want %0d/%0d", got64.size(), got8.size(), exp64.size(), exp8.size());
    else pass_cnt++;
    for (int i = 0; i < exp64.size() && i < got64.size(); i++) begin
      chk_cnt++;
      if (got64[i].a !== exp64[i].a || got64[i].b !== exp64[i].b || got64[i].o !== exp64[i].o)
        $display("FAIL rnd_pair64[%0d]: got %0d,%0d,%0b want %0d,%0d,%0b", i,
                 got64[i].a, got64[i].b, got64[i].o, exp64[i].a, exp64[i].b, exp64[i].o);
      else pass_cnt++;
    end
    for (int i = 0; i < exp8.size() && i < got8.size(); i++) begin
      chk_cnt++;
      if (got8[i].a !== exp8[i].a || got8[i].b !== exp8[i].b || got8[i].o !== exp8[i].o)
        $display("FAIL rnd_pair8[%0d]: got %0d,%0d,%0b want %0d,%0d,%0b", i,
                 got8[i].a, got8[i].b, got8[i].o, exp8[i].a, exp8[i].b, exp8[i].o);
      else pass_cnt++;
    end
    chk_cnt++;
    if (errs64 - e64 != exp_err || errs8 - e8 != exp_err)
      $display("FAIL rnd_errs: got %0d/%0d err pulses want %0d", errs64 - e64, errs8 - e8, exp_err);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_malformed();
    test_reset_midline();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
